// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words after reset
// or on request and flags whether they match the values this image was built with.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1445410163,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ID   = 3'd1,
        WAIT_ID = 3'd2,
        RD_TS   = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [2:0] LAT_LAST = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        m_read_q, m_read_d;
    logic        m_address_q, m_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_match_q, id_match_d;
    logic        ts_match_q, ts_match_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        start_pending_q, start_pending_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;

    logic accept;
    logic stall;
    logic stall_hit;
    logic lat_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            m_read_q        <= 1'b0;
            m_address_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            id_match_q      <= 1'b0;
            ts_match_q      <= 1'b0;
            timeout_q       <= 1'b0;
            id_value_q      <= 32'd0;
            ts_value_q      <= 32'd0;
            start_pending_q <= AUTO_START;
            stall_cnt_q     <= 8'd0;
            lat_cnt_q       <= 3'd0;
        end else begin
            state_q         <= state_d;
            m_read_q        <= m_read_d;
            m_address_q     <= m_address_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            id_match_q      <= id_match_d;
            ts_match_q      <= ts_match_d;
            timeout_q       <= timeout_d;
            id_value_q      <= id_value_d;
            ts_value_q      <= ts_value_d;
            start_pending_q <= start_pending_d;
            stall_cnt_q     <= stall_cnt_d;
            lat_cnt_q       <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        m_read_d        = m_read_q;
        m_address_d     = m_address_q;
        busy_d          = busy_q;
        done_d          = done_q;
        id_match_d      = id_match_q;
        ts_match_d      = ts_match_q;
        timeout_d       = timeout_q;
        id_value_d      = id_value_q;
        ts_value_d      = ts_value_q;
        start_pending_d = start_pending_q;
        stall_cnt_d     = stall_cnt_q;
        lat_cnt_d       = lat_cnt_q;

        accept    = m_read_q & ~m_waitrequest;
        stall     = m_read_q & m_waitrequest;
        // The counter value after this stall cycle is what must reach the limit.
        stall_hit = (TIMEOUT_CYCLES != 0) && stall && ((stall_cnt_q + 8'd1) == TO_LIMIT);
        lat_hit   = (lat_cnt_q == LAT_LAST);

        if (stall) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start || start_pending_q) begin
                    state_d         = RD_ID;
                    done_d          = 1'b0;
                    id_match_d      = 1'b0;
                    ts_match_d      = 1'b0;
                    timeout_d       = 1'b0;
                    start_pending_d = 1'b0;
                    busy_d          = 1'b1;
                    m_read_d        = 1'b1;
                    m_address_d     = 1'b0;
                    stall_cnt_d     = 8'd0;
                end
            end
            RD_ID, RD_TS: begin
                if (stall_hit) begin
                    state_d    = DONE;
                    m_read_d   = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                    id_match_d = 1'b0;
                    ts_match_d = 1'b0;
                end else if (accept) begin
                    if (READ_LATENCY == 0) begin
                        if (state_q == RD_ID) begin
                            id_value_d  = m_readdata;
                            state_d     = RD_TS;
                            m_address_d = 1'b1;
                            stall_cnt_d = 8'd0;
                        end else begin
                            ts_value_d = m_readdata;
                            state_d    = DONE;
                            m_read_d   = 1'b0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            id_match_d = (id_value_d == EXPECTED_ID);
                            ts_match_d = (ts_value_d == EXPECTED_TIMESTAMP);
                        end
                    end else begin
                        m_read_d  = 1'b0;
                        lat_cnt_d = 3'd0;
                        state_d   = (state_q == RD_ID) ? WAIT_ID : WAIT_TS;
                    end
                end
            end
            WAIT_ID: begin
                lat_cnt_d = lat_cnt_q + 3'd1;
                if (lat_hit) begin
                    id_value_d  = m_readdata;
                    state_d     = RD_TS;
                    m_read_d    = 1'b1;
                    m_address_d = 1'b1;
                    stall_cnt_d = 8'd0;
                end
            end
            WAIT_TS: begin
                lat_cnt_d = lat_cnt_q + 3'd1;
                if (lat_hit) begin
                    ts_value_d = m_readdata;
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    id_match_d = (id_value_d == EXPECTED_ID);
                    ts_match_d = (ts_value_d == EXPECTED_TIMESTAMP);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_read          = m_read_q;
    assign m_address       = m_address_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign id_match        = id_match_q;
    assign ts_match        = ts_match_q;
    assign timeout         = timeout_q;
    assign id_value        = id_value_q;
    assign timestamp_value = ts_value_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for the sysid checker: four instances (defaults, wrong timestamp, read latency 2,
// short timeout) each driven by a small sysid slave model.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] TS = 32'd1445410163;
    localparam int W = 75;

    logic        clk = 1'b0;
    logic [3:0]  rst = 4'hF;
    logic [3:0]  st = 4'h0;
    logic [3:0]  wr = 4'h0;
    logic [3:0]  m_read, m_addr, busy, done, idm, tsm, tmo;
    logic [31:0] rdata [4];
    logic [31:0] idv [4];
    logic [31:0] tsv [4];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    logic [31:0] read_bits, addr_bits, busy_bits, done_bits;
    logic [31:0] tsv_tr [32];
    logic        got_to, got_idm, got_tsm;
    logic [31:0] got_id, got_ts;
    int          dc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        nios_system_sysid_checker #(
            .EXPECTED_TIMESTAMP((g == 1) ? TS + 32'd1 : TS),
            .READ_LATENCY((g == 2) ? 2 : 0),
            .TIMEOUT_CYCLES((g == 3) ? 4 : 255),
            .AUTO_START(g == 0)
        ) u_dut (
            .clock(clk),
            .reset(rst[g]),
            .start(st[g]),
            .m_address(m_addr[g]),
            .m_read(m_read[g]),
            .m_waitrequest(wr[g]),
            .m_readdata(rdata[g]),
            .id_value(idv[g]),
            .timestamp_value(tsv[g]),
            .busy(busy[g]),
            .done(done[g]),
            .id_match(idm[g]),
            .ts_match(tsm[g]),
            .timeout(tmo[g])
        );
    end

    // Combinational sysid slaves.
    assign rdata[0] = m_addr[0] ? TS : 32'd0;
    assign rdata[1] = m_addr[1] ? TS : 32'd0;
    assign rdata[3] = m_addr[3] ? TS : 32'd0;

    // Latency-2 slave: data valid exactly two cycles after acceptance, garbage otherwise.
    logic p1_v = 1'b0, p1_a = 1'b0, p2_v = 1'b0, p2_a = 1'b0;
    always @(posedge clk) begin
        p1_v <= m_read[2] & ~wr[2];
        p1_a <= m_addr[2];
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign rdata[2] = p2_v ? (p2_a ? TS : 32'd0) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_res(input int cyc, input logic to, input logic im,
                                              input logic tm, input logic [31:0] id,
                                              input logic [31:0] ts);
        pack_res = {8'(cyc), to, im, tm, id, ts};
    endfunction

    // Cycle 0 is the current cycle; pattern bit c is driven during cycle c.
    task automatic run_check(input int idx, input logic [31:0] start_pat,
                             input logic [31:0] wr_pat, input logic [31:0] rst_pat,
                             input int max_cyc, output int done_cyc);
        done_cyc  = -1;
        read_bits = '0;
        addr_bits = '0;
        busy_bits = '0;
        done_bits = '0;
        for (int i = 0; i < 32; i++) tsv_tr[i] = '0;
        st[idx]  = start_pat[0];
        wr[idx]  = wr_pat[0];
        rst[idx] = rst_pat[0];
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            read_bits[c] = m_read[idx];
            addr_bits[c] = m_addr[idx];
            busy_bits[c] = busy[idx];
            done_bits[c] = done[idx];
            tsv_tr[c]    = tsv[idx];
            if (done[idx] && done_cyc < 0) begin
                done_cyc = c;
                got_to   = tmo[idx];
                got_idm  = idm[idx];
                got_tsm  = tsm[idx];
                got_id   = idv[idx];
                got_ts   = tsv[idx];
            end
            st[idx]  = start_pat[c];
            wr[idx]  = wr_pat[c];
            rst[idx] = rst_pat[c];
        end
        st[idx]  = 1'b0;
        wr[idx]  = 1'b0;
        rst[idx] = 1'b0;
    endtask

    task automatic score(input string name, input int done_cyc);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_eq({name, ".done_cycle"}, 64'(done_cyc), 64'(e[74:67]));
        if (done_cyc >= 0) begin
            check_eq({name, ".timeout"}, 64'(got_to), 64'(e[66]));
            check_eq({name, ".id_match"}, 64'(got_idm), 64'(e[65]));
            check_eq({name, ".ts_match"}, 64'(got_tsm), 64'(e[64]));
            check_eq({name, ".id_value"}, 64'(got_id), 64'(e[63:32]));
            check_eq({name, ".timestamp"}, 64'(got_ts), 64'(e[31:0]));
        end
    endtask

    initial begin
        repeat (3) tick();
        check_eq("reset.m_read", 64'(m_read), 64'h0);
        check_eq("reset.busy", 64'(busy), 64'h0);
        check_eq("reset.done", 64'(done), 64'h0);
        check_eq("reset.ts_value", 64'(tsv[0]), 64'h0);
        rst = 4'h0;

        // Auto check after reset release.
        exp_q.push_back(pack_res(3, 1'b0, 1'b1, 1'b1, 32'd0, TS));
        run_check(0, 32'h0, 32'h0, 32'h0, 8, dc);
        check_eq("auto.read", 64'(read_bits), 64'h6);
        check_eq("auto.addr", 64'(addr_bits & read_bits), 64'h4);
        check_eq("auto.busy", 64'(busy_bits), 64'h6);
        score("auto", dc);

        // Wrong expected timestamp; second start while busy must not retrigger.
        exp_q.push_back(pack_res(3, 1'b0, 1'b1, 1'b0, 32'd0, TS));
        run_check(1, 32'h3, 32'h0, 32'h0, 8, dc);
        check_eq("ts_bad.read", 64'(read_bits), 64'h6);
        check_eq("ts_bad.busy", 64'(busy_bits), 64'h6);
        score("ts_bad", dc);

        // Three stall cycles on the ID read.
        exp_q.push_back(pack_res(6, 1'b0, 1'b1, 1'b1, 32'd0, TS));
        run_check(0, 32'h1, 32'hE, 32'h0, 10, dc);
        check_eq("stall.read", 64'(read_bits), 64'h3E);
        check_eq("stall.addr", 64'(addr_bits & read_bits), 64'h20);
        check_eq("stall.busy", 64'(busy_bits), 64'h3E);
        score("stall", dc);

        // Read latency 2.
        exp_q.push_back(pack_res(7, 1'b0, 1'b1, 1'b1, 32'd0, TS));
        run_check(2, 32'h1, 32'h0, 32'h0, 10, dc);
        check_eq("lat.read", 64'(read_bits), 64'h12);
        check_eq("lat.addr", 64'(addr_bits & read_bits), 64'h10);
        check_eq("lat.busy", 64'(busy_bits), 64'h7E);
        score("lat", dc);

        // Waitrequest stuck high, timeout of 4.
        exp_q.push_back(pack_res(5, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
        run_check(3, 32'h1, 32'hFFFF_FFFF, 32'h0, 10, dc);
        check_eq("tmo.read", 64'(read_bits), 64'h1E);
        check_eq("tmo.busy", 64'(busy_bits), 64'h1E);
        score("tmo", dc);

        // Reset mid-check with a start while busy; auto check reruns afterwards.
        exp_q.push_back(pack_res(6, 1'b0, 1'b1, 1'b1, 32'd0, TS));
        run_check(0, 32'h3, 32'h0, 32'h4, 12, dc);
        check_eq("rst.read", 64'(read_bits), 64'h36);
        check_eq("rst.addr", 64'(addr_bits & read_bits), 64'h24);
        check_eq("rst.busy", 64'(busy_bits), 64'h36);
        check_eq("rst.done", 64'(done_bits), 64'h1FC0);
        check_eq("rst.ts_cleared", 64'(tsv_tr[3]), 64'h0);
        score("rst", dc);

        check_eq("scoreboard.empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
